// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared widths and in_sum bit positions for the FP adder post-add stage
package fp_add_pkg;
    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;
    localparam int SUM_W      = MAN_W + 5;
    localparam int BIAS       = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX    = (1 << EXP_W) - 1;
    localparam int CARRY_BIT  = MAN_W + 4;
    localparam int HIDDEN_BIT = MAN_W + 3;
    localparam int G_BIT      = 2;
    localparam int R_BIT      = 1;
    localparam int S_BIT      = 0;
endpackage

// File: rtl/fp_add_norm_round_if.sv
// fp_add_norm_round_if: input beat and result handshake bundle of the post-add stage
interface fp_add_norm_round_if #(
    parameter int EXP_W = fp_add_pkg::EXP_W,
    parameter int MAN_W = fp_add_pkg::MAN_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MAN_W+4:0]       in_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic                   out_overflow;
    logic                   out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_sum, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sum, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_inexact
    );
endinterface

// File: rtl/fp_add_norm_round_lzc.sv
// lzc: leading-zero count of i_data from the MSB; an all-zero input reports W
module lzc #(
    parameter int W  = 24,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_cnt
);
    // scan upward so the highest set bit has the final say
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
endmodule

// File: rtl/fp_add_norm_round.sv
// fp_add_norm_round: normalise, round-to-nearest-even and pack the adder's raw significand sum
module fp_add_norm_round #(
    parameter int EXP_W = fp_add_pkg::EXP_W,
    parameter int MAN_W = fp_add_pkg::MAN_W
) (
    input logic                clk,
    input logic                rst_n,
    fp_add_norm_round_if.slave bus
);
    import fp_add_pkg::*;

    localparam int CB = MAN_W + 4;           // carry position in in_sum
    localparam int NW = MAN_W + 4;           // significand plus G/R/S
    localparam int LW = $clog2(MAN_W + 2);   // leading-zero count range 0..MAN_W+1
    localparam int LSB = G_BIT + 1;          // significand LSB inside the normalised word

    logic [LW-1:0]        w_lz;
    logic [EXP_W:0]       w_em1, w_lzx, w_k, w_exp1, w_exp2;
    logic [NW-1:0]        w_norm;
    logic                 w_zero, w_sub1, w_s1_adv, w_s2_adv, w_inc, w_ovf;
    logic [MAN_W+1:0]     w_sig_rnd;
    logic [MAN_W:0]       w_sig;
    logic [EXP_W-1:0]     w_exp_pack;

    logic                 r_s1_valid, r_s1_sign, r_s1_sub;
    logic [EXP_W:0]       r_s1_exp;
    logic [NW-1:0]        r_s1_norm;
    logic                 r_s2_valid, r_s2_ovf, r_s2_inex;
    logic [EXP_W+MAN_W:0] r_s2_result;

    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1_valid;

    lzc #(.W(MAN_W + 1)) u_lzc (
        .i_data (bus.in_sum[MAN_W+3:LSB]),
        .o_cnt  (w_lz)
    );

    // S1: carry shifts right one place; otherwise shift left, but never past exponent 1
    assign w_zero = bus.in_sum == '0;
    assign w_em1  = {1'b0, bus.in_exp} - 1'b1;
    assign w_lzx  = (EXP_W+1)'(w_lz);
    assign w_k    = w_lzx < w_em1 ? w_lzx : w_em1;
    assign w_sub1 = w_zero || (w_k < w_lzx);
    assign w_norm = bus.in_sum[CB] ? {bus.in_sum[CB:R_BIT+1], |bus.in_sum[R_BIT:S_BIT]}
                                   : bus.in_sum[NW-1:0] << w_k;
    assign w_exp1 = w_zero ? '0 : bus.in_sum[CB] ? {1'b0, bus.in_exp} + 1'b1 : {1'b0, bus.in_exp} - w_k;

    // S2: round to nearest even, renormalise a rounding carry, flag overflow
    assign w_inc      = r_s1_norm[G_BIT] & (r_s1_norm[R_BIT] | r_s1_norm[S_BIT] | r_s1_norm[LSB]);
    assign w_sig_rnd  = {1'b0, r_s1_norm[NW-1:LSB]} + (MAN_W+2)'(w_inc);
    assign w_sig      = w_sig_rnd[MAN_W+1] ? {1'b1, {MAN_W{1'b0}}} : w_sig_rnd[MAN_W:0];
    assign w_exp2     = r_s1_exp + (EXP_W+1)'(w_sig_rnd[MAN_W+1]);
    assign w_ovf      = w_exp2 >= (EXP_W+1)'((1 << EXP_W) - 1);
    assign w_exp_pack = (r_s1_sub && !w_sig[MAN_W]) ? '0 : w_exp2[EXP_W-1:0];

    // S1 register: take a new beat whenever the stage can move forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_norm  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign <= bus.in_sign & ~w_zero;
                r_s1_sub  <= w_sub1;
                r_s1_exp  <= w_exp1;
                r_s1_norm <= w_norm;
            end
        end
    end

    // S2 register: hold the packed result until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_ovf    <= 1'b0;
            r_s2_inex   <= 1'b0;
            r_s2_result <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ovf    <= w_ovf;
                r_s2_inex   <= w_ovf | (|r_s1_norm[G_BIT:S_BIT]);
                r_s2_result <= w_ovf ? {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                     : {r_s1_sign, w_exp_pack, w_sig[MAN_W-1:0]};
            end
        end
    end

    assign bus.in_ready     = w_s1_adv;
    assign bus.out_valid    = r_s2_valid;
    assign bus.out_result   = r_s2_result;
    assign bus.out_overflow = r_s2_ovf;
    assign bus.out_inexact  = r_s2_inex;
endmodule

// File: tb/tb_fp_add_norm_round.sv
// tb_fp_add_norm_round: random and directed stimulus scored against an arithmetic model
module tb_fp_add_norm_round;
    import fp_add_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    bit   stalled = 0;
    bit   hold = 0;
    logic [33:0] held;
    logic [33:0] q[$];

    fp_add_norm_round_if bus ();

    fp_add_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {overflow, inexact, result} derived from the value of the sum, not from pipeline structure
    function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [27:0] sum);
        longint m, sig;
        int ex, lz, k, ee;
        bit sub, g, r, st;
        ee = int'(e);
        sub = 0;
        if (sum == 0) return 34'd0;
        if (sum[CARRY_BIT]) begin
            m = longint'(sum >> 1) | longint'(sum[0]);
            ex = ee + 1;
        end else begin
            lz = 0;
            while (lz < 24 && sum[HIDDEN_BIT - lz] == 1'b0) lz++;
            k = lz < ee - 1 ? lz : ee - 1;
            m = longint'(sum) << k;
            ex = ee - k;
            sub = k < lz;
        end
        sig = m >> 3;
        g = m[2];
        r = m[1];
        st = m[0];
        if (g && (r || st || sig[0])) sig++;
        if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            ex++;
        end
        if (ex >= EXP_MAX) return {1'b1, 1'b1, s, 8'hFF, 23'd0};
        return {1'b0, g | r | st, s, (sub && sig < (64'd1 << 23)) ? 8'd0 : 8'(ex), 23'(sig)};
    endfunction

    // scoreboard: record accepted beats, compare results in order, watch hold stability
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold = 0;
        end else begin
            if (hold) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", {bus.out_overflow, bus.out_inexact, bus.out_result}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else check("result", {bus.out_overflow, bus.out_inexact, bus.out_result}, q.pop_front());
                n_out++;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.out_overflow, bus.out_inexact, bus.out_result};
            if (bus.in_valid && !bus.in_ready) stalled = 1;
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_sign, bus.in_exp, bus.in_sum));
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] sum);
        int t = 0;
        bus.in_valid = 1;
        bus.in_sign = s;
        bus.in_exp = e;
        bus.in_sum = sum;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        bus.out_ready = 1;
        while ((q.size() != 0 || bus.out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_check(input logic [7:0] e, input logic [27:0] sum);
        bus.in_valid = 1;
        bus.in_sign = 0;
        bus.in_exp = e;
        bus.in_sum = sum;
        @(negedge clk);
        check("lat_accept", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 0;
        @(negedge clk);
        check("lat_cycle1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", bus.out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic s, input logic [7:0] e, input logic [27:0] sum,
                       input logic [33:0] exp);
        check(name, model(s, e, sum), exp);
    endtask

    function automatic logic [27:0] rand_sum();
        logic [27:0] r;
        int mode;
        r = 28'($urandom());
        mode = $urandom_range(0, 4);
        if (mode == 0) return r;
        if (mode == 1) return r & 28'h07FFFFF;
        if (mode == 2) return 28'($urandom_range(0, 255));
        if (mode == 3) return 28'h4000000 | (r & 28'h3FFFFFF);
        return 28'h7FFFFF8 | (r & 28'h7);
    endfunction

    function automatic logic [7:0] rand_exp();
        int m = $urandom_range(0, 3);
        if (m == 0) return 8'($urandom_range(1, 30));
        if (m == 1) return 8'($urandom_range(248, 254));
        return 8'($urandom_range(1, 254));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit done = 0;
        int base;
        bus.in_valid = 0;
        bus.in_sign = 0;
        bus.in_exp = 8'd1;
        bus.in_sum = '0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_flags", {bus.out_overflow, bus.out_inexact}, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1;

        pin("pin_one_plus_one", 0, 8'd127, 28'h8000000, {2'b00, 32'h40000000});
        pin("pin_cancel",       0, 8'd127, 28'h0000008, {2'b00, 32'h34000000});
        pin("pin_subnormal",    0, 8'd10,  28'h0000008, {2'b00, 32'h00000200});
        pin("pin_tie_odd",      0, 8'd127, 28'h400000C, {2'b01, 32'h3F800002});
        pin("pin_tie_even",     0, 8'd127, 28'h4000004, {2'b01, 32'h3F800000});
        pin("pin_round_carry",  0, 8'd127, 28'h7FFFFFC, {2'b01, 32'h40000000});
        pin("pin_overflow",     0, 8'd254, 28'h8000000, {2'b11, 32'h7F800000});
        pin("pin_neg_zero",     1, 8'd127, 28'h0000000, {2'b00, 32'h00000000});

        @(posedge clk);
        #1;
        lat_check(8'd127, 28'h8000000);
        send(0, 8'd127, 28'h0000008);
        send(0, 8'd10,  28'h0000008);
        send(0, 8'd127, 28'h400000C);
        send(0, 8'd127, 28'h4000004);
        send(1, 8'd127, 28'h7FFFFFC);
        send(0, 8'd254, 28'h8000000);
        send(1, 8'd127, 28'h0000000);
        drain();

        base = n_out;
        stalled = 0;
        fork
            begin
                send(0, 8'd127, 28'h8000000);
                send(1, 8'd127, 28'h0000000);
                send(0, 8'd127, 28'h400000C);
                send(1, 8'd60,  28'h0123458);
                send(0, 8'd254, 28'h8000000);
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    @(posedge clk);
                    #1 bus.out_ready = !(c >= 3 && c <= 6);
                end
            end
        join
        drain();
        check("bp_stalled", stalled, 1);
        check("bp_count", n_out - base, 5);

        bus.out_ready = 0;
        send(0, 8'd127, 28'h8000000);
        send(0, 8'd127, 28'h4000004);
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        check("full_out_valid", bus.out_valid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_result", {bus.out_overflow, bus.out_inexact, bus.out_result}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        lat_check(8'd127, 28'h400000C);
        drain();

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(0, 1)), rand_exp(), rand_sum());
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
